// File: rtl/instr_pkg.sv
// Shared types, constants and instruction-word field helpers for the dispatch block.
package instr_pkg;

  // Widest supported configuration. The helpers work on words zero-extended to this size.
  localparam int unsigned MAX_N = 16;
  localparam int unsigned MAX_W = 8 + 32 * MAX_N;

  localparam logic [7:0] ERR_ILLEGAL = 8'hEE;
  localparam logic [7:0] ERR_TIMEOUT = 8'hEF;

  typedef enum logic [3:0] {
    CmdNop     = 4'h0,
    CmdLoadA   = 4'h1,
    CmdLoadB   = 4'h2,
    CmdCompute = 4'h3,
    CmdReadC   = 4'h4
  } cmd_e;

  typedef enum logic [2:0] {
    StArmRx,
    StWaitRx,
    StDecode,
    StWrite,
    StComp,
    StRead,
    StResp,
    StWaitTx
  } state_e;

  // Word layout for n entries per row: {OPCODE[7:0], VALUES[16n-1:0], INDICES[16n-1:0]}.
  function automatic logic [7:0] opcode_of(input logic [MAX_W-1:0] word, input int unsigned n);
    return word[32*n +: 8];
  endfunction

  // Returns the value field in the low 16n bits; upper bits are zero.
  function automatic logic [16*MAX_N-1:0] values_of(input logic [MAX_W-1:0] word,
                                                    input int unsigned n);
    logic [16*MAX_N-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < 16 * MAX_N; i++) begin
      if (i < 16 * n) res[i] = word[16*n + i];
    end
    return res;
  endfunction

  // Returns the index field in the low 16n bits; upper bits are zero.
  function automatic logic [16*MAX_N-1:0] indices_of(input logic [MAX_W-1:0] word,
                                                     input int unsigned n);
    logic [16*MAX_N-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < 16 * MAX_N; i++) begin
      if (i < 16 * n) res[i] = word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/instr_watchdog.sv
// Cycle counter guarding the wait for the multiplier; flags the last allowed cycle.
module instr_watchdog #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [31:0] count_q;

  // Clear has priority over counting so a fresh compute always starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 32'd1;
    end
  end

  // With the count cleared on entry, this is high on the TIMEOUT-th counted cycle.
  assign tc = (count_q == 32'(TIMEOUT - 1));

endmodule

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: receives words from comm, drives the matrix store and multiplier,
// and answers every instruction with one response word.
module instr_dispatch
  import instr_pkg::*;
#(
  parameter int unsigned MATRIX_N = 4,
  parameter int unsigned TIMEOUT  = 1000000,
  localparam int unsigned W       = 8 + 32 * MATRIX_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_complete,
  input  logic [W-1:0]            rx_data,
  input  logic                    tx_complete,
  input  logic                    busy,
  output logic                    op,
  output logic                    start,
  output logic [W-1:0]            tx_data,
  output logic                    mat_we_a,
  output logic                    mat_we_b,
  output logic [3:0]              mat_row,
  output logic [16*MATRIX_N-1:0]  mat_values,
  output logic [16*MATRIX_N-1:0]  mat_indices,
  output logic                    compute_start,
  input  logic                    compute_done,
  output logic                    c_re,
  input  logic [16*MATRIX_N-1:0]  c_values,
  input  logic [16*MATRIX_N-1:0]  c_indices,
  output logic [15:0]             instr_count
);

  localparam int unsigned VW = 16 * MATRIX_N;

  state_e         state_q, state_d;
  logic [W-1:0]   rx_q, rx_d;
  logic [W-1:0]   tx_q, tx_d;
  logic           op_q, op_d;
  logic           start_q, start_d;
  logic           we_a_q, we_a_d;
  logic           we_b_q, we_b_d;
  logic           cstart_q, cstart_d;
  logic           c_re_q, c_re_d;
  logic [3:0]     row_q, row_d;
  logic [VW-1:0]  vals_q, vals_d;
  logic [VW-1:0]  idx_q, idx_d;
  logic [15:0]    count_q, count_d;
  logic           wd_clear, wd_en, wd_tc;
  logic           illegal;

  logic [MAX_W-1:0]     word_ext;
  logic [16*MAX_N-1:0]  vals_ext, idx_ext;
  logic [7:0]           opcode;
  cmd_e                 cmd;
  logic [3:0]           row;
  logic                 row_ok;
  logic [W-1:0]         ack_word, err_ill_word, err_to_word, read_word;
  logic                 unused_ext;

  assign word_ext   = MAX_W'(rx_q);
  assign opcode     = opcode_of(word_ext, MATRIX_N);
  assign vals_ext   = values_of(word_ext, MATRIX_N);
  assign idx_ext    = indices_of(word_ext, MATRIX_N);
  assign cmd        = cmd_e'(opcode[7:4]);
  assign row        = opcode[3:0];
  assign row_ok     = (32'(row) < MATRIX_N);
  assign unused_ext = ^{word_ext, vals_ext, idx_ext};

  instr_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .tc     (wd_tc)
  );

  // Candidate response words built from the latched opcode.
  always_comb begin
    ack_word                = '0;
    ack_word[W-1 -: 8]      = opcode;
    err_ill_word            = '0;
    err_ill_word[W-1 -: 8]  = ERR_ILLEGAL;
    err_ill_word[7:0]       = opcode;
    err_to_word             = '0;
    err_to_word[W-1 -: 8]   = ERR_TIMEOUT;
    err_to_word[7:0]        = opcode;
    read_word               = {opcode, c_values, c_indices};
  end

  // Next state and next registered outputs; every output is a flop so it reads 0 out of reset.
  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    op_d     = op_q;
    start_d  = 1'b0;
    we_a_d   = 1'b0;
    we_b_d   = 1'b0;
    cstart_d = 1'b0;
    c_re_d   = 1'b0;
    row_d    = row_q;
    vals_d   = vals_q;
    idx_d    = idx_q;
    count_d  = count_q;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      StArmRx: begin
        op_d = 1'b0;
        if (!busy) begin
          start_d = 1'b1;
          state_d = StWaitRx;
        end
      end
      StWaitRx: begin
        if (rx_complete) begin
          rx_d    = rx_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (cmd)
          CmdNop: begin
            tx_d    = ack_word;
            op_d    = 1'b1;
            state_d = StResp;
          end
          CmdLoadA, CmdLoadB: begin
            if (row_ok) begin
              we_a_d  = (cmd == CmdLoadA);
              we_b_d  = (cmd == CmdLoadB);
              row_d   = row;
              vals_d  = vals_ext[VW-1:0];
              idx_d   = idx_ext[VW-1:0];
              state_d = StWrite;
            end else begin
              illegal = 1'b1;
            end
          end
          CmdCompute: begin
            cstart_d = 1'b1;
            wd_clear = 1'b1;
            state_d  = StComp;
          end
          CmdReadC: begin
            if (row_ok) begin
              c_re_d  = 1'b1;
              row_d   = row;
              state_d = StRead;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
          tx_d    = err_ill_word;
          op_d    = 1'b1;
          state_d = StResp;
        end
      end
      StWrite: begin
        tx_d    = ack_word;
        op_d    = 1'b1;
        state_d = StResp;
      end
      StComp: begin
        wd_en = 1'b1;
        // A done arriving on the terminal cycle still wins.
        if (compute_done) begin
          tx_d    = ack_word;
          op_d    = 1'b1;
          state_d = StResp;
        end else if (wd_tc) begin
          tx_d    = err_to_word;
          op_d    = 1'b1;
          state_d = StResp;
        end
      end
      StRead: begin
        // First cycle carries c_re; C data is valid on the second.
        if (!c_re_q) begin
          tx_d    = read_word;
          op_d    = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (!busy) begin
          start_d = 1'b1;
          state_d = StWaitTx;
        end
      end
      StWaitTx: begin
        if (tx_complete) begin
          count_d = count_q + 16'd1;
          op_d    = 1'b0;
          state_d = StArmRx;
        end
      end
      default: state_d = StArmRx;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StArmRx;
      rx_q     <= '0;
      tx_q     <= '0;
      op_q     <= 1'b0;
      start_q  <= 1'b0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      cstart_q <= 1'b0;
      c_re_q   <= 1'b0;
      row_q    <= '0;
      vals_q   <= '0;
      idx_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      op_q     <= op_d;
      start_q  <= start_d;
      we_a_q   <= we_a_d;
      we_b_q   <= we_b_d;
      cstart_q <= cstart_d;
      c_re_q   <= c_re_d;
      row_q    <= row_d;
      vals_q   <= vals_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
    end
  end

  assign op            = op_q;
  assign start         = start_q;
  assign tx_data       = tx_q;
  assign mat_we_a      = we_a_q;
  assign mat_we_b      = we_b_q;
  assign mat_row       = row_q;
  assign mat_values    = vals_q;
  assign mat_indices   = idx_q;
  assign compute_start = cstart_q;
  assign c_re          = c_re_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed, table-driven bench for instr_dispatch with a small comm/multiplier/C-store model.
module tb_instr_dispatch;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8 + 32 * N;
  localparam int unsigned TO = 20;

  logic           clk = 1'b0;
  logic           reset, rx_complete, tx_complete, busy, compute_done;
  logic [W-1:0]   rx_data, tx_data;
  logic           op, start, mat_we_a, mat_we_b, compute_start, c_re;
  logic [3:0]     mat_row;
  logic [63:0]    mat_values, mat_indices, c_values, c_indices;
  logic [15:0]    instr_count;

  instr_dispatch #(
    .MATRIX_N (N),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_complete   (rx_complete),
    .rx_data       (rx_data),
    .tx_complete   (tx_complete),
    .busy          (busy),
    .op            (op),
    .start         (start),
    .tx_data       (tx_data),
    .mat_we_a      (mat_we_a),
    .mat_we_b      (mat_we_b),
    .mat_row       (mat_row),
    .mat_values    (mat_values),
    .mat_indices   (mat_indices),
    .compute_start (compute_start),
    .compute_done  (compute_done),
    .c_re          (c_re),
    .c_values      (c_values),
    .c_indices     (c_indices),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] tx;
    int           we_a;
    int           we_b;
    int           cs;
    int           cre;
    int           done_at;    // COMP cycle (1-based) to pulse compute_done, 0 = never
    int           busy_hold;  // cycles to hold busy once in RESP
    int           op_rise;    // expected COMP cycle index when op rises, 0 = unchecked
  } vec_t;

  vec_t vecs[12];

  int n_cmp = 0;
  int n_bad = 0;
  int arm_target = 0;
  int tx_target  = 0;
  int done_at    = 0;

  // Monitor state
  int           cyc = 0, rx_cyc = 0, we_lat = 0;
  int           arm_n = 0, tx_n = 0, start_n = 0;
  int           we_a_n = 0, we_b_n = 0, cs_n = 0, cre_n = 0, bad_start = 0;
  int           cnt_q = 0, op_rise_idx = 0;
  logic         start_op = 1'b0, op_prev = 1'b0, cre_prev = 1'b0;
  logic [3:0]   we_row = '0;
  logic [63:0]  we_vals = '0, we_idx = '0;
  int           comp_idx;

  // Index of the current COMP cycle, starting at 1 on the compute_start cycle.
  assign comp_idx     = compute_start ? 1 : ((cnt_q != 0) ? cnt_q + 1 : 0);
  assign compute_done = (done_at != 0) && (comp_idx == done_at);
  // C store answers one cycle after the read strobe.
  assign c_values     = cre_prev ? 64'h0009_0008_0007_0006 : 64'h0;
  assign c_indices    = cre_prev ? 64'h0003_0002_0001_0000 : 64'h0;

  // Event counters and captures, sampled on the active edge.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    cnt_q    <= comp_idx;
    op_prev  <= op;
    cre_prev <= c_re;
    if (rx_complete) rx_cyc <= cyc;
    if (start) begin
      start_n  <= start_n + 1;
      start_op <= op;
      if (op) tx_n <= tx_n + 1;
      else    arm_n <= arm_n + 1;
      if (busy) bad_start <= bad_start + 1;
    end
    if (mat_we_a || mat_we_b) begin
      we_lat  <= cyc - rx_cyc;
      we_row  <= mat_row;
      we_vals <= mat_values;
      we_idx  <= mat_indices;
    end
    if (mat_we_a) we_a_n <= we_a_n + 1;
    if (mat_we_b) we_b_n <= we_b_n + 1;
    if (compute_start) cs_n <= cs_n + 1;
    if (c_re) cre_n <= cre_n + 1;
    if (op && !op_prev) op_rise_idx <= comp_idx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return arm_n;
      1:       return tx_n;
      default: return start_n;
    endcase
  endfunction

  task automatic wait_ge(input string name, input int sel, input int target);
    for (int k = 0; k < 200; k++) begin
      if (cnt_of(sel) >= target) begin
        n_cmp++;
        return;
      end
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, count %0d required %0d", name, cnt_of(sel), target);
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] o, input logic [63:0] v,
                                      input logic [63:0] x);
    return {o, v, x};
  endfunction

  function automatic logic [W-1:0] err(input logic [7:0] code, input logic [7:0] o);
    return {code, 120'h0, o};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_op"},     W'(op), '0);
    check({tag, "_start"},  W'(start), '0);
    check({tag, "_tx"},     tx_data, '0);
    check({tag, "_we"},     W'({mat_we_a, mat_we_b, compute_start, c_re}), '0);
    check({tag, "_row"},    W'(mat_row), '0);
    check({tag, "_mat"},    W'({mat_values, mat_indices}), '0);
    check({tag, "_count"},  W'(instr_count), '0);
  endtask

  task automatic do_instr(input vec_t v, input int exp_count);
    int we_a0, we_b0, cs0, cre0, tx0;
    we_a0 = we_a_n; we_b0 = we_b_n; cs0 = cs_n; cre0 = cre_n;
    done_at = v.done_at;
    arm_target++;
    wait_ge("arm_rx", 0, arm_target);
    rx_data     = v.rx;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    rx_data     = '0;
    if (v.busy_hold > 0) begin
      busy = 1'b1;
      for (int k = 0; k < 50 && !op; k++) tick();
      check("resp_reached", W'(op), W'(1'b1));
      tx0 = tx_n;
      repeat (v.busy_hold) tick();
      check("no_start_busy", W'(tx_n), W'(tx0));
      busy = 1'b0;
      tick();
      check("start_after_busy", W'(start), W'(1'b1));
    end
    tx_target++;
    wait_ge("tx_start", 1, tx_target);
    check("tx_data", tx_data, v.tx);
    check("tx_op", W'(op), W'(1'b1));
    // Stray receive while transmitting must be ignored.
    rx_data     = mk(8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    rx_data     = '0;
    check("tx_hold", tx_data, v.tx);
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
    check("instr_count", W'(instr_count), W'(exp_count));
    check("we_a_pulses", W'(we_a_n - we_a0), W'(v.we_a));
    check("we_b_pulses", W'(we_b_n - we_b0), W'(v.we_b));
    check("cstart_pulses", W'(cs_n - cs0), W'(v.cs));
    check("c_re_pulses", W'(cre_n - cre0), W'(v.cre));
    if (v.we_a + v.we_b > 0) begin
      check("we_latency", W'(we_lat), W'(2));
      check("we_row", W'(we_row), W'(v.rx[W-5 -: 4]));
      check("we_values", W'(we_vals), W'(v.rx[W-9 -: 64]));
      check("we_indices", W'(we_idx), W'(v.rx[63:0]));
    end
    if (v.op_rise != 0) check("resp_cycle", W'(op_rise_idx), W'(v.op_rise));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0;
    vecs[0]  = '{mk(8'h12, 64'h0001_0002_0003_0004, 64'h0000_0001_0002_0003),
                 mk(8'h12, 64'h0, 64'h0), 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{mk(8'h20, 64'h0005_0006_0007_0008, 64'h0003_0002_0001_0000),
                 mk(8'h20, 64'h0, 64'h0), 0, 1, 0, 0, 0, 10, 0};
    vecs[2]  = '{mk(8'h30, 64'h0, 64'h0), mk(8'h30, 64'h0, 64'h0), 0, 0, 1, 0, 15, 0, 16};
    vecs[3]  = '{mk(8'h41, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_5678_9ABC_DEF0),
                 mk(8'h41, 64'h0009_0008_0007_0006, 64'h0003_0002_0001_0000), 0, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{mk(8'h95, 64'h1, 64'h2), err(8'hEE, 8'h95), 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{mk(8'h25, 64'h0001_0001_0001_0001, 64'h0), err(8'hEE, 8'h25), 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{mk(8'h45, 64'h0, 64'h0), err(8'hEE, 8'h45), 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{mk(8'h07, 64'h5555, 64'h6666), mk(8'h07, 64'h0, 64'h0), 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{mk(8'h3A, 64'h0, 64'h0), err(8'hEF, 8'h3A), 0, 0, 1, 0, 0, 0, 21};
    vecs[9]  = '{mk(8'h30, 64'h0, 64'h0), mk(8'h30, 64'h0, 64'h0), 0, 0, 1, 0, 20, 0, 21};
    vecs[10] = '{mk(8'h13, 64'hFFFF_0000_8000_0001, 64'h0000_0003_0002_0001),
                 mk(8'h13, 64'h0, 64'h0), 1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{mk(8'h14, 64'h7, 64'h7), err(8'hEE, 8'h14), 0, 0, 0, 0, 0, 0, 0};

    reset       = 1'b1;
    rx_complete = 1'b0;
    tx_complete = 1'b0;
    busy        = 1'b0;
    rx_data     = '0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) do_instr(vecs[i], i + 1);

    // Reset while waiting for tx_complete aborts the response.
    done_at = 0;
    arm_target++;
    wait_ge("rst_arm", 0, arm_target);
    rx_data     = mk(8'h11, 64'h0001_0002_0003_0004, 64'h0);
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
    rx_data     = '0;
    tx_target++;
    wait_ge("rst_tx_start", 1, tx_target);
    reset = 1'b1;
    tick();
    check_zero("midrst");
    reset = 1'b0;
    s0 = start_n;
    wait_ge("rst_restart", 2, s0 + 1);
    check("restart_op", W'(start_op), W'(1'b0));

    do_instr('{mk(8'h00, 64'h0, 64'h0), mk(8'h00, 64'h0, 64'h0), 0, 0, 0, 0, 0, 0, 0}, 1);

    check("start_while_busy", W'(bad_start), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
